// File: rtl/ex_div_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_div_if
// Purpose  : Request/response bundle between the EX stage (master) and the
//            iterative divider (slave).
// Signals  : dividend, divisor, op, start       master -> slave
//            is_running, quotient_out,
//            remainder_out, done                 slave  -> master
// Revision : 1.0 - initial release
// ============================================================================
interface ex_div_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic [1:0]            op;
  logic                  start;
  logic                  is_running;
  logic [DATA_WIDTH-1:0] quotient_out;
  logic [DATA_WIDTH-1:0] remainder_out;
  logic                  done;

  modport master (
    output dividend, divisor, op, start,
    input  is_running, quotient_out, remainder_out, done
  );

  modport slave (
    input  dividend, divisor, op, start,
    output is_running, quotient_out, remainder_out, done
  );

endinterface

`default_nettype wire

// File: rtl/ex_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_div_unit
// Purpose  : Iterative radix-2 restoring divider for the DIV.W, MOD.W,
//            DIV.WU and MOD.WU instructions. One quotient bit per cycle;
//            both quotient and remainder are produced for every op.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            bus  - ex_div_if.slave (dividend, divisor, op, start in;
//                   is_running, quotient_out, remainder_out, done out)
// Options  : DIV_EARLY_OUT_EN - when defined, |dividend| < |divisor| skips
//            the iteration and finishes one cycle after acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module ex_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic      clk,
  input  logic      rst,
  ex_div_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] c_last_iter = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);

  state_e                state_q,    state_d;
  logic [CNT_WIDTH-1:0]  cnt_q,      cnt_d;
  logic [DATA_WIDTH-1:0] rem_q,      rem_d;      // partial remainder
  logic [DATA_WIDTH-1:0] dvd_q,      dvd_d;      // dividend magnitude, becomes quotient
  logic [DATA_WIDTH-1:0] dvs_q,      dvs_d;      // divisor magnitude
  logic                  sign_a_q,   sign_a_d;
  logic                  sign_b_q,   sign_b_d;
  logic                  uns_q,      uns_d;
  logic                  bypass_q,   bypass_d;   // results already final, no sign fix-up
  logic [DATA_WIDTH-1:0] quot_out_q, quot_out_d;
  logic [DATA_WIDTH-1:0] rem_out_q,  rem_out_d;
  logic                  done_q,     done_d;

  // --------------------------------------------------------------------------
  // Operand conditioning at acceptance
  // --------------------------------------------------------------------------
  logic                  w_uns_in;
  logic                  w_sign_a;
  logic                  w_sign_b;
  logic [DATA_WIDTH-1:0] w_mag_a;
  logic [DATA_WIDTH-1:0] w_mag_b;
  logic                  w_div_zero;
  logic                  w_early;
  logic                  w_accept;

  assign w_uns_in   = bus.op[1];
  assign w_sign_a   = bus.dividend[DATA_WIDTH-1] & ~w_uns_in;
  assign w_sign_b   = bus.divisor[DATA_WIDTH-1]  & ~w_uns_in;
  assign w_mag_a    = w_sign_a ? -bus.dividend : bus.dividend;
  assign w_mag_b    = w_sign_b ? -bus.divisor  : bus.divisor;
  assign w_div_zero = (bus.divisor == '0);

`ifdef DIV_EARLY_OUT_EN
  // Magnitudes are compared unsigned so that 0x8000_0000 counts as 2^31.
  assign w_early = (w_mag_a < w_mag_b);
`else
  assign w_early = 1'b0;
`endif

  // The cycle in which done is visible closes the FINISH phase; a start seen
  // there belongs to the finished operation's window and is dropped.
  assign w_accept = (state_q == ST_IDLE) && bus.start && !done_q;

  // --------------------------------------------------------------------------
  // One restoring step. The shifted remainder is below 2*divisor, so the
  // (DATA_WIDTH+1)-bit difference has its MSB set exactly when negative.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH:0]   w_shift;
  logic [DATA_WIDTH:0]   w_trial;

  assign w_shift = {rem_q, dvd_q[DATA_WIDTH-1]};
  assign w_trial = w_shift - {1'b0, dvs_q};

  // --------------------------------------------------------------------------
  // Sign fix-up (wraps mod 2^DATA_WIDTH, so the overflow case falls out)
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_q_fix;
  logic [DATA_WIDTH-1:0] w_r_fix;

  assign w_q_fix = (!uns_q && (sign_a_q ^ sign_b_q)) ? -dvd_q : dvd_q;
  assign w_r_fix = (!uns_q && sign_a_q)              ? -rem_q : rem_q;

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    uns_d      = uns_q;
    bypass_d   = bypass_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          sign_a_d = w_sign_a;
          sign_b_d = w_sign_b;
          uns_d    = w_uns_in;
          cnt_d    = '0;
          if (w_div_zero) begin
            dvd_d    = '1;
            rem_d    = bus.dividend;
            dvs_d    = '0;
            bypass_d = 1'b1;
            state_d  = ST_FINISH;
          end else if (w_early) begin
            dvd_d    = '0;
            rem_d    = bus.dividend;
            dvs_d    = w_mag_b;
            bypass_d = 1'b1;
            state_d  = ST_FINISH;
          end else begin
            dvd_d    = w_mag_a;
            dvs_d    = w_mag_b;
            rem_d    = '0;
            bypass_d = 1'b0;
            state_d  = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (!w_trial[DATA_WIDTH]) begin
          rem_d = w_trial[DATA_WIDTH-1:0];
          dvd_d = {dvd_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          rem_d = w_shift[DATA_WIDTH-1:0];
          dvd_d = {dvd_q[DATA_WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + c_cnt_one;
        if (cnt_q == c_last_iter) begin
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        quot_out_d = bypass_q ? dvd_q : w_q_fix;
        rem_out_d  = bypass_q ? rem_q : w_r_fix;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      uns_q      <= 1'b0;
      bypass_q   <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      uns_q      <= uns_d;
      bypass_q   <= bypass_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      done_q     <= done_d;
    end
  end

  assign bus.is_running    = (state_q != ST_IDLE);
  assign bus.done          = done_q;
  assign bus.quotient_out  = quot_out_q;
  assign bus.remainder_out = rem_out_q;

endmodule

`default_nettype wire
